// File: rtl/ps2_mouse_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_packet_rx
//  Brief    : Device-to-host PS/2 receiver. Deserialises 11-bit frames and
//             assembles 3-byte mouse movement packets (dx/dy/sx/sy/btn/ovf).
//  Revision : 1.0  initial release
// ============================================================================
module ps2_mouse_packet_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic       sx,
  output logic       sy,
  output logic [2:0] btn,
  output logic [1:0] ovf,
  output logic       done_ld,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // [0],[1] form the synchroniser, [2] remembers the previous synced level
  logic [2:0]       clk_sync_q;
  logic [1:0]       dat_sync_q;
  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic             par_q, par_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       b0_q, b0_d;
  logic [7:0]       b1_q, b1_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [7:0]       dx_q, dx_d, dy_q, dy_d;
  logic             sx_q, sx_d, sy_q, sy_d;
  logic [2:0]       btn_q, btn_d;
  logic [1:0]       ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             w_fall;
  logic             w_dat;
  logic             w_byte_ok;

  assign w_fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign w_dat  = dat_sync_q[1];

  // Two-flop synchronisers for the asynchronous PS/2 pins plus edge history
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
    end
  end

  // Frame FSM, byte assembly and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      idx_q    <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      tcnt_q   <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      btn_q    <= '0;
      ovf_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      idx_q    <= idx_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      tcnt_q   <= tcnt_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      btn_q    <= btn_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state: bit deserialisation on synced falls, timeout, packet commit
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    par_d     = par_q;
    idx_d     = idx_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    tcnt_d    = tcnt_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    btn_d     = btn_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    w_byte_ok = 1'b0;

    if (w_fall) begin
      tcnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!w_dat) begin
            state_d  = S_DATA;
            shift_d  = '0;
            bitcnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d  = {w_dat, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = w_dat;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (w_dat && (^{shift_q, par_q})) w_byte_ok = 1'b1;
          else                              err_d     = 1'b1;
        end
      endcase
    end else if (state_q != S_IDLE) begin
      // Stalled frame: abandon it and the partially received byte
      if (tcnt_q == C_TMO_LAST) begin
        state_d = S_IDLE;
        tcnt_d  = '0;
        err_d   = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end

    if (w_byte_ok) begin
      case (idx_q)
        2'd0: begin
          // Byte 0 always has bit 3 set; anything else means we are misaligned
          if (shift_q[3]) begin
            b0_d  = shift_q;
            idx_d = 2'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        2'd1: begin
          b1_d  = shift_q;
          idx_d = 2'd2;
        end
        default: begin
          idx_d  = 2'd0;
          dx_d   = b1_q;
          dy_d   = shift_q;
          sx_d   = b0_q[4];
          sy_d   = b0_q[5];
          btn_d  = b0_q[2:0];
          ovf_d  = b0_q[7:6];
          done_d = 1'b1;
        end
      endcase
    end

    if (err_d) idx_d = 2'd0;
  end

  assign dx        = dx_q;
  assign dy        = dy_q;
  assign sx        = sx_q;
  assign sy        = sy_q;
  assign btn       = btn_q;
  assign ovf       = ovf_q;
  assign done_ld   = done_q;
  assign frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_packet_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_mouse_packet_rx
//  Brief    : Self-checking bench for ps2_mouse_packet_rx with an event-level
//             reference model of frames and packet assembly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_mouse_packet_rx;

  localparam int TO   = 300;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] dx, dy;
  logic       sx, sy;
  logic [2:0] btn;
  logic [1:0] ovf;
  logic       done_ld, frame_err;

  ps2_mouse_packet_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .dx(dx), .dy(dy), .sx(sx), .sy(sy), .btn(btn), .ovf(ovf),
    .done_ld(done_ld), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] b0, b1, b2;
    int         ref_cyc, lo, hi;
  } ev_t;

  ev_t        evq[$];
  ev_t        e;
  logic [7:0] pend[$];
  int         n_checks = 0, n_pass = 0, n_done = 0, last_fall = 0;
  bit         mon_en = 1'b0;
  logic [7:0] exp_dx = 0, exp_dy = 0;
  logic       exp_sx = 0, exp_sy = 0;
  logic [2:0] exp_btn = 0;
  logic [1:0] exp_ovf = 0;

  function automatic void chk(input bit ok, input string name,
                              input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void lit(input string name, input longint act, input longint exp);
    chk(act == exp, name, act, exp);
  endfunction

  // Reference model: one call per completed frame, at its final pin fall
  function automatic void model_byte(input logic [7:0] b, input bit good);
    ev_t x;
    x.ref_cyc = last_fall; x.lo = 3; x.hi = 4;
    x.b0 = 0; x.b1 = 0; x.b2 = 0;
    if (!good || (pend.size() == 0 && !b[3])) begin
      x.is_err = 1'b1;
      evq.push_back(x);
      pend.delete();
    end else begin
      pend.push_back(b);
      if (pend.size() == 3) begin
        x.is_err = 1'b0;
        x.b0 = pend[0]; x.b1 = pend[1]; x.b2 = pend[2];
        evq.push_back(x);
        pend.delete();
      end
    end
  endfunction

  // Compare DUT against the model on every cycle out of reset
  always @(negedge clk) begin
    if (mon_en && resetn) begin
      if (done_ld) n_done++;
      if (done_ld && frame_err) chk(1'b0, "both_pulses", 1, 0);
      if (done_ld || frame_err) begin
        if (evq.size() == 0) begin
          chk(1'b0, "unexpected_pulse", {done_ld, frame_err}, 0);
        end else begin
          e = evq.pop_front();
          chk(frame_err == e.is_err, "event_kind", frame_err, e.is_err);
          chk((cyc - e.ref_cyc) >= e.lo && (cyc - e.ref_cyc) <= e.hi,
              "latency", cyc - e.ref_cyc, e.lo);
          if (!e.is_err) begin
            exp_dx = e.b1; exp_dy = e.b2;
            exp_sx = e.b0[4]; exp_sy = e.b0[5];
            exp_btn = e.b0[2:0]; exp_ovf = e.b0[7:6];
          end
        end
      end else if (evq.size() != 0 && cyc > evq[0].ref_cyc + evq[0].hi) begin
        chk(1'b0, evq[0].is_err ? "missing_frame_err" : "missing_done_ld", 0, 1);
        void'(evq.pop_front());
      end
      chk({dx, dy, sx, sy, btn, ovf} == {exp_dx, exp_dy, exp_sx, exp_sy, exp_btn, exp_ovf},
          "outputs", {dx, dy, sx, sy, btn, ovf},
          {exp_dx, exp_dy, exp_sx, exp_sy, exp_btn, exp_ovf});
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bit_fall(input logic b);
    ps2_dat = b;
    wait_clks(HALF);
    #($urandom_range(1, 8));
    ps2_clk   = 1'b0;
    last_fall = cyc;
  endtask

  task automatic bit_rise();
    wait_clks(HALF);
    #2;
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit_fall(1'b0); bit_rise();
    for (int i = 0; i < 8; i++) begin bit_fall(b[i]); bit_rise(); end
    bit_fall((~^b) ^ bad_par); bit_rise();
    bit_fall(!bad_stop);
    model_byte(b, !bad_par && !bad_stop);
    bit_rise();
    ps2_dat = 1'b1;
    wait_clks(5 + $urandom_range(0, 10));
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_frame(a, 0, 0); send_frame(b, 0, 0); send_frame(c, 0, 0);
  endtask

  // Start bit plus n data bits, then the clock stops until the frame times out
  task automatic stall_frame(input int nbits);
    ev_t x;
    bit_fall(1'b0); bit_rise();
    for (int i = 0; i < nbits; i++) begin bit_fall($urandom_range(0, 1)); bit_rise(); end
    x.is_err = 1'b1; x.b0 = 0; x.b1 = 0; x.b2 = 0;
    x.ref_cyc = last_fall; x.lo = TO + 2; x.hi = TO + 5;
    evq.push_back(x);
    pend.delete();
    ps2_dat = 1'b1;
    wait_clks(TO + 50);
  endtask

  task automatic check_zero_outputs(input string tag);
    lit({tag, "_dx"}, dx, 0);
    lit({tag, "_dy"}, dy, 0);
    lit({tag, "_sxsy"}, {sx, sy}, 0);
    lit({tag, "_btn_ovf"}, {btn, ovf}, 0);
    lit({tag, "_pulses"}, {done_ld, frame_err}, 0);
  endtask

  initial begin
    int d0;
    wait_clks(3);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;
    wait_clks(3);
    mon_en = 1'b1;

    // Basic packet
    d0 = n_done;
    send_pkt(8'h28, 8'h05, 8'hFB);
    lit("t1_dx", dx, 8'h05); lit("t1_dy", dy, 8'hFB);
    lit("t1_sx", sx, 0); lit("t1_sy", sy, 1);
    lit("t1_btn_ovf", {btn, ovf}, 0);
    lit("t1_done_count", n_done - d0, 1);

    // Negative X with left button
    send_pkt(8'h19, 8'h80, 8'h01);
    lit("t2_dx", dx, 8'h80); lit("t2_sx", sx, 1);
    lit("t2_btn", btn, 3'b001); lit("t2_dy", dy, 8'h01); lit("t2_sy", sy, 0);

    // Bad parity, then a good packet
    d0 = n_done;
    send_frame(8'h28, 1, 0);
    lit("t3_dx_held", dx, 8'h80);
    send_pkt(8'h28, 8'h05, 8'hFB);
    lit("t3_dx", dx, 8'h05); lit("t3_done_count", n_done - d0, 1);

    // Bad stop bit in the middle of a packet
    send_frame(8'h09, 0, 0);
    send_frame(8'h33, 0, 1);
    send_pkt(8'h0A, 8'h7F, 8'h81);
    lit("stop_dx", dx, 8'h7F); lit("stop_btn", btn, 3'b010);

    // Misaligned stream
    send_frame(8'h05, 0, 0);
    send_pkt(8'h28, 8'h05, 8'hFB);
    lit("t4_dx", dx, 8'h05); lit("t4_dy", dy, 8'hFB);

    // Timeout inside a frame, also mid-packet
    stall_frame(4);
    send_frame(8'h08, 0, 0);
    stall_frame(6);
    send_pkt(8'hCC, 8'h12, 8'h34);
    lit("t5_dx", dx, 8'h12); lit("t5_ovf", ovf, 2'b11); lit("t5_btn", btn, 3'b100);

    // Asynchronous reset during byte 1
    send_frame(8'h08, 0, 0);
    bit_fall(1'b0); bit_rise();
    for (int i = 0; i < 3; i++) begin bit_fall(1'b1); bit_rise(); end
    ps2_dat = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    check_zero_outputs("t6");
    evq.delete(); pend.delete();
    exp_dx = 0; exp_dy = 0; exp_sx = 0; exp_sy = 0; exp_btn = 0; exp_ovf = 0;
    wait_clks(4);
    @(negedge clk);
    resetn = 1'b1;
    wait_clks(5);
    d0 = n_done;
    send_pkt(8'h38, 8'hF0, 8'h0F);
    lit("t6_dx", dx, 8'hF0); lit("t6_sy", sy, 1); lit("t6_done_count", n_done - d0, 1);

    // Randomised frames with occasional corruption and stalls
    for (int i = 0; i < 45; i++) begin
      if ($urandom_range(0, 14) == 0) stall_frame($urandom_range(1, 9));
      else send_frame($urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end

    wait_clks(20);
    lit("events_drained", evq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
